// File: rtl/cic3_seq_pkg.sv
// Shared types and sizes for the CIC3 row readout sequencer.
package cic3_seq_pkg;

  localparam int NUM_CH   = 12;
  localparam int DATA_W   = 25;
  localparam int CH_IDX_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } seq_state_e;

endpackage

// File: rtl/cic3_row_readout_seq_if.sv
// Valid/ready readout stream carrying one captured channel per beat.
interface cic3_row_readout_seq_if
  import cic3_seq_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int IW = CH_IDX_W
);

  logic [DW-1:0] dout;
  logic [IW-1:0] dout_chan;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_first;
  logic          dout_last;

  modport master (
    output dout, dout_chan, dout_valid, dout_first, dout_last,
    input  dout_ready
  );

  modport slave (
    input  dout, dout_chan, dout_valid, dout_first, dout_last,
    output dout_ready
  );

endinterface

// File: rtl/cic3_next_chan.sv
// Finds the next higher set bit of a channel mask, or the lowest one when start is set.
module cic3_next_chan
  import cic3_seq_pkg::*;
#(
  parameter int N     = NUM_CH,
  parameter int IDX_W = CH_IDX_W
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] idx,
  input  logic             start,
  output logic [IDX_W-1:0] next_idx,
  output logic             none_left
);

  // Scanning downward lets the lowest qualifying bit win.
  always_comb begin
    next_idx  = '0;
    none_left = 1'b1;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask[k] && (start || (k > int'(idx)))) begin
        next_idx  = IDX_W'(k);
        none_left = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cic3_row_readout_seq.sv
// Snapshots a 12-filter CIC3 row on each sample tick and streams the enabled channels out.
module cic3_row_readout_seq
  import cic3_seq_pkg::*;
#(
  parameter int NUM_CH    = cic3_seq_pkg::NUM_CH,
  parameter int DATA_W    = cic3_seq_pkg::DATA_W,
  parameter int OVR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH*DATA_W-1:0] filt_out,
  input  logic                     sample_tick,
  input  logic [NUM_CH-1:0]        chan_en,
  input  logic                     clr_overrun,
  output logic                     overrun,
  output logic [OVR_CNT_W-1:0]     overrun_cnt,
  output logic                     busy,
  cic3_row_readout_seq_if.master   stream
);

  seq_state_e                 state_q, state_d;
  logic [DATA_W-1:0]          shadow_q [NUM_CH];
  logic [DATA_W-1:0]          shadow_d [NUM_CH];
  logic [NUM_CH-1:0]          mask_q, mask_d;
  logic [CH_IDX_W-1:0]        ptr_q, ptr_d;
  logic                       first_q, first_d;
  logic                       overrun_q, overrun_d;
  logic [OVR_CNT_W-1:0]       ovr_cnt_q, ovr_cnt_d;

  logic [CH_IDX_W-1:0]        first_idx, next_idx;
  logic                       first_none, last_chan;
  logic                       beat, capture, drop;

  cic3_next_chan #(.N(NUM_CH), .IDX_W(CH_IDX_W)) u_first_chan (
    .mask      (chan_en),
    .idx       ('0),
    .start     (1'b1),
    .next_idx  (first_idx),
    .none_left (first_none)
  );

  cic3_next_chan #(.N(NUM_CH), .IDX_W(CH_IDX_W)) u_next_chan (
    .mask      (mask_q),
    .idx       (ptr_q),
    .start     (1'b0),
    .next_idx  (next_idx),
    .none_left (last_chan)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      for (int k = 0; k < NUM_CH; k++) shadow_q[k] <= '0;
      mask_q    <= '0;
      ptr_q     <= '0;
      first_q   <= 1'b0;
      overrun_q <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      mask_q    <= mask_d;
      ptr_q     <= ptr_d;
      first_q   <= first_d;
      overrun_q <= overrun_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  // A tick landing on the last beat reloads the bank instead of counting as a drop.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    mask_d    = mask_q;
    ptr_d     = ptr_q;
    first_d   = first_q;
    overrun_d = overrun_q;
    ovr_cnt_d = ovr_cnt_q;
    capture   = 1'b0;
    beat      = (state_q == SEND) && stream.dout_ready;

    unique case (state_q)
      IDLE: begin
        if (sample_tick && !first_none) begin
          capture = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (beat) begin
          if (!last_chan) begin
            ptr_d   = next_idx;
            first_d = 1'b0;
          end else if (sample_tick && !first_none) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      for (int k = 0; k < NUM_CH; k++) shadow_d[k] = filt_out[k*DATA_W +: DATA_W];
      mask_d  = chan_en;
      ptr_d   = first_idx;
      first_d = 1'b1;
    end

    drop = (state_q == SEND) && sample_tick && !(beat && last_chan);

    if (clr_overrun) begin
      overrun_d = drop;
      ovr_cnt_d = drop ? OVR_CNT_W'(1) : '0;
    end else if (drop) begin
      overrun_d = 1'b1;
      if (ovr_cnt_q != '1) ovr_cnt_d = ovr_cnt_q + 1'b1;
    end
  end

  always_comb begin
    stream.dout       = '0;
    stream.dout_chan  = '0;
    stream.dout_valid = (state_q == SEND);
    stream.dout_first = (state_q == SEND) && first_q;
    stream.dout_last  = (state_q == SEND) && last_chan;
    if (state_q == SEND) begin
      stream.dout_chan = ptr_q;
      for (int k = 0; k < NUM_CH; k++) begin
        if (ptr_q == CH_IDX_W'(k)) stream.dout = shadow_q[k];
      end
    end
    busy        = (state_q == SEND);
    overrun     = overrun_q;
    overrun_cnt = ovr_cnt_q;
  end

endmodule

// File: tb/tb_cic3_row_readout_seq.sv
// Directed bench for the CIC3 row readout sequencer with hand-computed expectations.
module tb_cic3_row_readout_seq;

  localparam int NCH = 12;
  localparam int DW  = 25;

  logic            clk;
  logic            reset_n;
  logic [NCH*DW-1:0] filt_out;
  logic            sample_tick;
  logic [NCH-1:0]  chan_en;
  logic            clr_overrun;
  logic            overrun;
  logic [7:0]      overrun_cnt;
  logic            busy;

  int testCount = 0;
  int failCount = 0;

  cic3_row_readout_seq_if #(.DW(DW), .IW(4)) stream ();

  cic3_row_readout_seq #(.NUM_CH(NCH), .DATA_W(DW), .OVR_CNT_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .filt_out    (filt_out),
    .sample_tick (sample_tick),
    .chan_en     (chan_en),
    .clr_overrun (clr_overrun),
    .overrun     (overrun),
    .overrun_cnt (overrun_cnt),
    .busy        (busy),
    .stream      (stream.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic loadFilters(input int base);
    for (int k = 0; k < NCH; k++) filt_out[k*DW +: DW] = DW'(base + k);
  endtask

  // Drive one cycle: tick and ready apply to the coming edge, then sample #1 after it.
  task automatic applyStimulus(input logic tick, input logic rdy);
    sample_tick       = tick;
    stream.dout_ready = rdy;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_dout"},  32'(stream.dout), 0);
    checkOutput({tag, "_chan"},  32'(stream.dout_chan), 0);
    checkOutput({tag, "_valid"}, 32'(stream.dout_valid), 0);
    checkOutput({tag, "_first"}, 32'(stream.dout_first), 0);
    checkOutput({tag, "_last"},  32'(stream.dout_last), 0);
    checkOutput({tag, "_busy"},  32'(busy), 0);
    checkOutput({tag, "_ovr"},   32'(overrun), 0);
    checkOutput({tag, "_cnt"},   32'(overrun_cnt), 0);
  endtask

  initial begin
    int idx;
    int exp_ch [3];
    logic rdy;
    logic tick;
    exp_ch[0] = 0; exp_ch[1] = 5; exp_ch[2] = 11;

    reset_n = 1'b0;
    sample_tick = 1'b0;
    chan_en = '0;
    clr_overrun = 1'b0;
    stream.dout_ready = 1'b0;
    loadFilters(0);
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset_n = 1'b1;

    // All channels, ready high.
    chan_en = 12'hFFF;
    loadFilters(100);
    applyStimulus(1'b1, 1'b1);
    for (int b = 0; b < 12; b++) begin
      checkOutput("full_valid", 32'(stream.dout_valid), 1);
      checkOutput("full_dout",  32'(stream.dout), 32'(100 + b));
      checkOutput("full_chan",  32'(stream.dout_chan), 32'(b));
      checkOutput("full_first", 32'(stream.dout_first), 32'(b == 0));
      checkOutput("full_last",  32'(stream.dout_last), 32'(b == 11));
      applyStimulus(1'b0, 1'b1);
    end
    checkOutput("full_busy_end", 32'(busy), 0);
    checkOutput("full_valid_end", 32'(stream.dout_valid), 0);

    // Sparse mask with toggling ready; mask and data changes mid-frame must not leak in.
    chan_en = 12'h821;
    loadFilters(200);
    applyStimulus(1'b1, 1'b1);
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      rdy = (c % 2 == 0);
      checkOutput("sparse_valid", 32'(stream.dout_valid), 1);
      checkOutput("sparse_chan",  32'(stream.dout_chan), 32'(exp_ch[idx]));
      checkOutput("sparse_dout",  32'(stream.dout), 32'(200 + exp_ch[idx]));
      checkOutput("sparse_first", 32'(stream.dout_first), 32'(idx == 0));
      checkOutput("sparse_last",  32'(stream.dout_last), 32'(idx == 2));
      if (c == 1) begin
        chan_en = 12'hFFF;
        loadFilters(300);
      end
      applyStimulus(1'b0, rdy);
      if (rdy) idx++;
    end
    checkOutput("sparse_valid_end", 32'(stream.dout_valid), 0);

    // Ready stuck low while ticks keep arriving every 8 cycles.
    chan_en = 12'hFFF;
    loadFilters(400);
    for (int c = 0; c < 20; c++) begin
      if (c == 4) loadFilters(500);
      applyStimulus(c % 8 == 0, 1'b0);
      if (c == 8) begin
        checkOutput("ovr_first_flag", 32'(overrun), 1);
        checkOutput("ovr_first_cnt",  32'(overrun_cnt), 1);
      end
    end
    checkOutput("ovr_flag",  32'(overrun), 1);
    checkOutput("ovr_cnt",   32'(overrun_cnt), 2);
    checkOutput("ovr_valid", 32'(stream.dout_valid), 1);
    checkOutput("ovr_chan",  32'(stream.dout_chan), 0);
    for (int b = 0; b < 12; b++) begin
      checkOutput("ovr_drain_dout", 32'(stream.dout), 32'(400 + b));
      applyStimulus(1'b0, 1'b1);
    end
    checkOutput("ovr_drain_valid", 32'(stream.dout_valid), 0);
    clr_overrun = 1'b1;
    applyStimulus(1'b0, 1'b1);
    clr_overrun = 1'b0;
    checkOutput("ovr_clr_flag", 32'(overrun), 0);
    checkOutput("ovr_clr_cnt",  32'(overrun_cnt), 0);

    // Tick period equal to frame length: frames abut with no bubble.
    chan_en = 12'hFFF;
    for (int c = 0; c <= 36; c++) begin
      if (c >= 1) begin
        checkOutput("b2b_valid", 32'(stream.dout_valid), 1);
        checkOutput("b2b_chan",  32'(stream.dout_chan), 32'((c - 1) % 12));
        checkOutput("b2b_dout",  32'(stream.dout), 32'(600 + 100 * ((c - 1) / 12) + (c - 1) % 12));
      end
      tick = (c % 12 == 0) && (c < 36);
      if (tick) loadFilters(600 + 100 * (c / 12));
      applyStimulus(tick, 1'b1);
    end
    checkOutput("b2b_valid_end", 32'(stream.dout_valid), 0);
    checkOutput("b2b_no_ovr",    32'(overrun), 0);

    // Saturation of the drop counter and clear-with-drop priority.
    chan_en = 12'h001;
    loadFilters(800);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("sat_cnt",  32'(overrun_cnt), 255);
    checkOutput("sat_flag", 32'(overrun), 1);
    clr_overrun = 1'b1;
    applyStimulus(1'b1, 1'b0);
    clr_overrun = 1'b0;
    checkOutput("clrdrop_cnt",  32'(overrun_cnt), 1);
    checkOutput("clrdrop_flag", 32'(overrun), 1);
    clr_overrun = 1'b1;
    applyStimulus(1'b0, 1'b0);
    clr_overrun = 1'b0;
    checkOutput("clr_cnt",     32'(overrun_cnt), 0);
    checkOutput("sat_dout",    32'(stream.dout), 800);
    checkOutput("sat_last",    32'(stream.dout_last), 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("sat_drain_valid", 32'(stream.dout_valid), 0);

    // Tick with an empty mask is ignored.
    chan_en = 12'h000;
    applyStimulus(1'b1, 1'b1);
    checkOutput("empty_valid", 32'(stream.dout_valid), 0);
    checkOutput("empty_ovr",   32'(overrun), 0);

    // Asynchronous reset in the middle of a frame.
    chan_en = 12'hFFF;
    loadFilters(700);
    applyStimulus(1'b1, 1'b1);
    for (int b = 0; b < 5; b++) begin
      checkOutput("rst_pre_chan", 32'(stream.dout_chan), 32'(b));
      applyStimulus(b == 2, 1'b1);
    end
    checkOutput("rst_beat5_chan", 32'(stream.dout_chan), 5);
    checkOutput("rst_beat5_ovr",  32'(overrun), 1);
    reset_n = 1'b0;
    #1;
    checkAllZero("midrst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    checkOutput("postrst_valid", 32'(stream.dout_valid), 0);
    chan_en = 12'h0F0;
    applyStimulus(1'b1, 1'b1);
    checkOutput("postrst_valid1", 32'(stream.dout_valid), 1);
    checkOutput("postrst_chan",   32'(stream.dout_chan), 4);
    checkOutput("postrst_dout",   32'(stream.dout), 704);
    checkOutput("postrst_first",  32'(stream.dout_first), 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
